// File: rtl/cmp_seq_if.sv
// Handshake and operand bundle for cmp_seq: operand/cascade input channel
// and result output channel, each with its own valid/ready pair.
interface cmp_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             fi_big;
    logic             fi_equal;
    logic             fi_small;
    logic             out_valid;
    logic             out_ready;
    logic             fo_big;
    logic             fo_equal;
    logic             fo_small;

    modport master (
        output in_valid, a, b, fi_big, fi_equal, fi_small, out_ready,
        input  in_ready, out_valid, fo_big, fo_equal, fo_small
    );

    modport slave (
        input  in_valid, a, b, fi_big, fi_equal, fi_small, out_ready,
        output in_ready, out_valid, fo_big, fo_equal, fo_small
    );
endinterface

// File: rtl/cmp_seq.sv
// Multi-cycle magnitude comparator: CHUNK bits per clock, MSB chunk first,
// early exit on the first unequal chunk. Define CMP_SIGNED_EN for two's complement.
module cmp_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 4
) (
    input  logic     sys_clk,
    input  logic     sys_rst_n,
    cmp_seq_if.slave bus
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

    // Result encoding {big, equal, small}
    localparam logic [2:0] RES_BIG   = 3'b100;
    localparam logic [2:0] RES_EQUAL = 3'b010;
    localparam logic [2:0] RES_SMALL = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       fi_q, fi_d;
    logic [2:0]       fo_q, fo_d;
    logic             out_valid_q, out_valid_d;

    logic [CHUNK-1:0] a_ch, b_ch;
    logic [2:0]       casc_res;
    logic             accept;

    assign bus.in_ready  = (state_q == S_IDLE) && sys_rst_n;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.fo_big    = fo_q[2];
    assign bus.fo_equal  = fo_q[1];
    assign bus.fo_small  = fo_q[0];

    // Current chunk of each registered operand
    always_comb begin
        a_ch = '0;
        b_ch = '0;
        for (int unsigned i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_ch = a_q[i*CHUNK +: CHUNK];
                b_ch = b_q[i*CHUNK +: CHUNK];
            end
        end
`ifdef CMP_SIGNED_EN
        // Flipping the sign bit turns a two's-complement compare into unsigned
        if (idx_q == IDX_TOP) begin
            a_ch[CHUNK-1] = ~a_ch[CHUNK-1];
            b_ch[CHUNK-1] = ~b_ch[CHUNK-1];
        end
`endif
    end

    // All chunks equal: big wins over small; no flag set still reports equal
    always_comb begin
        casez (fi_q)
            3'b1??:  casc_res = RES_BIG;
            3'b0?1:  casc_res = RES_SMALL;
            default: casc_res = RES_EQUAL;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        fi_d        = fi_q;
        fo_d        = fo_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    fi_d    = {bus.fi_big, bus.fi_equal, bus.fi_small};
                    idx_d   = IDX_TOP;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (a_ch > b_ch) begin
                    fo_d        = RES_BIG;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else if (a_ch < b_ch) begin
                    fo_d        = RES_SMALL;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else if (idx_q == '0) begin
                    fo_d        = casc_res;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    fo_d        = '0;
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                fo_d        = '0;
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= IDX_TOP;
            a_q         <= '0;
            b_q         <= '0;
            fi_q        <= '0;
            fo_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            fi_q        <= fi_d;
            fo_q        <= fo_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_cmp_seq.sv
// Randomized self-checking bench for cmp_seq: a CHUNK=4 and a CHUNK=32 instance
// checked against a whole-word reference model of result and latency.
module tb_cmp_seq;
    localparam int unsigned W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cmp_seq_if #(.WIDTH(W)) bus4  ();
    cmp_seq_if #(.WIDTH(W)) bus32 ();

    cmp_seq #(.WIDTH(W), .CHUNK(4)) u_dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus4.slave)
    );

    cmp_seq #(.WIDTH(W), .CHUNK(32)) u_dut32 (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus32.slave)
    );

    logic         sel = 1'b0;   // 0: CHUNK=4 instance, 1: CHUNK=32 instance
    logic         drv_valid = 1'b0;
    logic         drv_ordy  = 1'b0;
    logic [W-1:0] drv_a = '0;
    logic [W-1:0] drv_b = '0;
    logic [2:0]   drv_fi = 3'b010;  // {big, equal, small}

    assign bus4.in_valid  = drv_valid & ~sel;
    assign bus4.out_ready = drv_ordy  & ~sel;
    assign bus4.a         = drv_a;
    assign bus4.b         = drv_b;
    assign bus4.fi_big    = drv_fi[2];
    assign bus4.fi_equal  = drv_fi[1];
    assign bus4.fi_small  = drv_fi[0];

    assign bus32.in_valid  = drv_valid & sel;
    assign bus32.out_ready = drv_ordy  & sel;
    assign bus32.a         = drv_a;
    assign bus32.b         = drv_b;
    assign bus32.fi_big    = drv_fi[2];
    assign bus32.fi_equal  = drv_fi[1];
    assign bus32.fi_small  = drv_fi[0];

    wire       obs_rdy = sel ? bus32.in_ready  : bus4.in_ready;
    wire       obs_ov  = sel ? bus32.out_valid : bus4.out_valid;
    wire [2:0] obs_fo  = sel ? {bus32.fo_big, bus32.fo_equal, bus32.fo_small}
                             : {bus4.fo_big,  bus4.fo_equal,  bus4.fo_small};

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Whole-word comparison, then cascade priority big > small > equal
    function automatic logic [2:0] model_res(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] fi);
        logic gt, lt;
`ifdef CMP_SIGNED_EN
        gt = $signed(a) > $signed(b);
        lt = $signed(a) < $signed(b);
`else
        gt = a > b;
        lt = a < b;
`endif
        if (gt)    return 3'b100;
        if (lt)    return 3'b001;
        if (fi[2]) return 3'b100;
        if (fi[0]) return 3'b001;
        return 3'b010;
    endfunction

    // Chunks examined: up to and including the one holding the highest differing bit
    function automatic int model_k(input logic [31:0] a, input logic [31:0] b, input int chunk);
        logic [31:0] x;
        int nch;
        x   = a ^ b;
        nch = 32 / chunk;
        for (int p = 31; p >= 0; p--) begin
            if (x[p]) return nch - p / chunk;
        end
        return nch;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; hold = cycles the consumer stalls once the result is up
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] fi, input int hold);
        int chunk, nch, edges;
        logic [2:0] exp_r;
        int exp_k;
        bit seen, idle_zero;
        chunk     = sel ? 32 : 4;
        nch       = 32 / chunk;
        exp_r     = model_res(a, b, fi);
        exp_k     = model_k(a, b, chunk);
        edges     = 0;
        seen      = 0;
        idle_zero = 1;

        drv_a = a; drv_b = b; drv_fi = fi;
        drv_valid = 1'b1;
        drv_ordy  = 1'b0;
        check("ready_idle", 32'(obs_rdy), 32'd1);
        tick();
        // inputs change after accept and must not affect the result
        drv_valid = 1'b0;
        drv_a  = $urandom;
        drv_b  = $urandom;
        drv_fi = 3'($urandom);

        // Deciding chunk k compared on edge k after the accept edge
        for (int i = 0; i < nch + 4 && !seen; i++) begin
            tick();
            edges++;
            seen = obs_ov;
            if (!seen && obs_fo != 3'b000) idle_zero = 0;
        end
        check("done_seen", 32'(seen), 32'd1);
        if (!seen) return;
        check("latency", 32'(edges), 32'(exp_k));
        check("result", 32'(obs_fo), 32'(exp_r));
        check("fo_zero_busy", 32'(idle_zero), 32'd1);

        // New operands offered while stalled must be ignored
        drv_valid = (hold > 0);
        drv_a = $urandom; drv_b = $urandom;
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_stable", {28'd0, obs_ov, obs_fo}, {28'd0, 1'b1, exp_r});
            check("hold_no_ready", 32'(obs_rdy), 32'd0);
        end
        drv_valid = 1'b0;
        drv_ordy  = 1'b1;
        tick();
        drv_ordy  = 1'b0;
        check("release", {28'd0, obs_ov, obs_fo}, 32'd0);
        check("ready_after", 32'(obs_rdy), 32'd1);
    endtask

    function automatic logic [31:0] near(input logic [31:0] a);
        logic [31:0] r;
        case ($urandom_range(3, 0))
            0:       r = a;
            1:       r = a ^ (32'd1 << $urandom_range(31, 0));
            2:       r = a + 32'($urandom_range(3, 0));
            default: r = $urandom;
        endcase
        return r;
    endfunction

    initial begin
        int acc_cnt, last_acc, spacing_ok;
        logic [31:0] ra;

        // Reset state
        #1;
        check("rst_ready", 32'(obs_rdy), 32'd0);
        check("rst_ov", 32'(obs_ov), 32'd0);
        check("rst_fo", 32'(obs_fo), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", 32'(obs_rdy), 32'd1);

        // Directed cases on CHUNK=4
        sel = 1'b0;
        run_op(32'h8000_0000, 32'h7FFF_FFFF, 3'b010, 0);
        run_op(32'h1234_5678, 32'h1234_5679, 3'b010, 0);
        run_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b001, 0);
        run_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b101, 0);
        run_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b000, 0);
        run_op(32'h0000_00F0, 32'h0000_00F1, 3'b010, 5);
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 3'b010, 0);

        // Reset while in RUN with index 5: abort, no result emitted
        drv_a = 32'h1234_5678; drv_b = 32'h1234_5679; drv_fi = 3'b010;
        drv_valid = 1'b1;
        tick();
        drv_valid = 1'b0;
        tick();
        tick();
        check("pre_abort_ov", 32'(obs_ov), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_ov", 32'(obs_ov), 32'd0);
        check("abort_fo", 32'(obs_fo), 32'd0);
        check("abort_ready", 32'(obs_rdy), 32'd0);
        tick();
        #3;
        rst_n = 1'b1;
        acc_cnt = 0;
        drv_ordy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (obs_ov) acc_cnt++;
        end
        drv_ordy = 1'b0;
        check("abort_no_result", 32'(acc_cnt), 32'd0);
        check("abort_idle", 32'(obs_rdy), 32'd1);
        run_op(32'd3, 32'd3, 3'b010, 0);

        // Randomized CHUNK=4
        for (int n = 0; n < 150; n++) begin
            ra = $urandom;
            run_op(ra, near(ra), 3'($urandom), int'($urandom_range(3, 0)));
        end

        // CHUNK=32 instance
        sel = 1'b1;
        tick();
        run_op(32'd5, 32'd9, 3'b010, 0);
        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            run_op(ra, near(ra), 3'($urandom), int'($urandom_range(2, 0)));
        end

        // Back-to-back on CHUNK=32: an accept every third edge
        drv_a = 32'd5; drv_b = 32'd9; drv_fi = 3'b010;
        drv_valid = 1'b1;
        drv_ordy  = 1'b1;
        acc_cnt = 0; last_acc = -1; spacing_ok = 1;
        for (int i = 0; i < 12; i++) begin
            if (obs_rdy) begin
                if (last_acc >= 0 && i - last_acc != 3) spacing_ok = 0;
                last_acc = i;
                acc_cnt++;
            end
            if (obs_ov) check("b2b_result", 32'(obs_fo), 32'(3'b001));
            tick();
        end
        drv_valid = 1'b0;
        check("b2b_accepts", 32'(acc_cnt), 32'd4);
        check("b2b_spacing", 32'(spacing_ok), 32'd1);
        for (int i = 0; i < 4 && !obs_rdy; i++) tick();
        drv_ordy = 1'b0;
        check("b2b_drain", 32'(obs_rdy), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
